nn_cfg_loader: RTL and testbench
================================

# nn_cfg_loader

Configuration sequencer for the neural-network layers. Accepts a single 32-bit command stream through a valid/ready port and parses headers. It drives the shared weight/bias loading bus (`weightValid`, `biasValid`, `weightValue`, `biasValue`, `config_layer_num`, `config_neuron_num`) that every neuron decodes against its own layer/neuron ID. It sits between the host/DMA interface and the layer array and is the only driver of that bus.

## Interface
- `NUM_LAYERS`, 4: layers present; a header layer field ≥ this is an error.
- `MAX_NEURONS`, 32: neurons per layer; a header neuron field ≥ this is an error.
- `MAX_WEIGHTS`, 784: maximum weight words per neuron.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cfg_data` in 32: command word.
- `cfg_valid` in 1: `cfg_data` valid.
- `cfg_ready` out 1: word accepted when `cfg_valid & cfg_ready`.
- `weightValid` out 1: one-cycle weight strobe.
- `biasValid` out 1: one-cycle bias strobe.
- `weightValue` out 32: weight payload.
- `biasValue` out 32: bias payload.
- `config_layer_num` out 32: target layer, zero-extended from 6 bits.
- `config_neuron_num` out 32: target neuron, zero-extended from 10 bits.
- `busy` out 1: state ≠ IDLE/DONE.
- `done` out 1: sticky, end marker received.
- `err` out 1: sticky, any error seen.
- `err_code` out 2: first error: 0 none, 1 bad layer/neuron, 2 bad count, 3 checksum.

## Operation
- Header word fields:
  - [31:30] type: 01 weight, 10 bias, 11 end, 00 reserved (treated as bad count).
  - [29:24] layer.
  - [23:14] neuron.
  - [13:0] count.
- States: IDLE, WEIGHT, BIAS, SKIP, DONE.
- IDLE:
  - Accepts a header and latches layer and neuron into `config_*_num`, then loads the payload counter with count.
  - Weight type → WEIGHT. Requires 1 ≤ count ≤ `MAX_WEIGHTS`.
  - Bias type → BIAS. Requires count == 1.
  - End type → DONE.
- WEIGHT/BIAS:
  - Each accepted word is registered to `weightValue`/`biasValue` and the matching strobe pulses for one cycle.
  - The counter decrements per accepted word. The last word returns the FSM to IDLE.
- Errors:
  - Bad layer or neuron with a legal count → SKIP. Consumes count payload words with no strobes, then returns to IDLE. Sets `err`; `err_code` = 1 if not already set.
  - Count of 0, count > `MAX_WEIGHTS`, a bias count ≠ 1, or type 00 → stays in IDLE. The header is consumed and `err_code` = 2 if not already set. The host must not send payload words after such a header.
- DONE: `cfg_ready`=0 and `done`=1 until `rst`.
- `cfg_ready` is 1 in IDLE, WEIGHT, BIAS and SKIP.
- `config_*_num` hold their value after a burst until the next header is accepted.
- Strobes never assert in IDLE, SKIP or DONE. `weightValid` and `biasValid` are never high in the same cycle.

## Timing
- Reset values:
  - `cfg_ready`=0 in the `rst` cycle, then 1 in the following cycle.
  - All strobes 0, all value and number outputs 0.
  - `busy`, `done`, `err` = 0; `err_code` = 0.
  - State IDLE.
- Latency: a payload accepted at edge N produces its strobe and value in cycle N+1. Throughput is one word per cycle.
- `config_*_num` are updated at the header's acceptance edge, so they are stable at least one cycle before the first strobe.
- Gaps in `cfg_valid` mid-burst: the FSM holds state and counter, and no strobe is issued.
- The last payload and the next header may be back-to-back. The FSM is in IDLE in the cycle after the last payload.
- `rst` mid-burst: the FSM aborts to IDLE and the in-flight strobe is suppressed in the next cycle. A neuron's weight write address restarts only if the neuron is reset too; the system resets both together.

## Configuration
- `NN_CFG_CHECKSUM_EN` defined:
  - A 32-bit modulo-2^32 sum accumulates over all payload words accepted in WEIGHT and BIAS. Words in SKIP are excluded.
  - The end word's [15:0] is compared with sum[15:0]. On mismatch, `err` is set; `err_code` = 3 if not already set.
  - The FSM enters DONE regardless of the comparison.
- Undefined: end word bits [29:0] are ignored and no accumulator is built.

## Structure
- `nn_cfg_pkg` holds:
  - Header field bit positions.
  - Type codes: TYPE_WEIGHT, TYPE_BIAS, TYPE_END.
  - Error codes.
  - State enum.
- No sub-module. The FSM, counter and checksum accumulator live in one module.

## Test plan
- Weight burst: header W, L1, N3, count 4, then 0x11..0x14 back-to-back → 4 `weightValid` pulses carrying 0x11..0x14 with layer=1 and neuron=3. Back in IDLE in the cycle after the last payload.
- Bias with valid gaps: header B, L0, N7, count 1, with 3 idle cycles before the payload 0xFFF0 → a single `biasValid` pulse with 0xFFF0, one cycle after acceptance.
- Bad layer: header W, L9 (NUM_LAYERS=4), count 2, followed by 2 words → no strobes, `err`=1, `err_code`=1. A following valid header loads normally.
- Bad count: header W, count 0 → no state change, `err_code`=2. Header B, count 2 leaves `err_code` = 2 (first error retained).
- End marker: header E → `done`=1, `cfg_ready`=0, `busy`=0. Further `cfg_valid` is ignored.
- Reset mid-burst: `rst` after 2 of 5 weights → no strobe after the reset cycle, and all outputs return to their reset values. With `NN_CFG_CHECKSUM_EN`, weights 1,2,3 followed by end[15:0]=5 → `err_code`=3.

Source files
------------

// File: rtl/nn_cfg_pkg.sv
// Shared definitions for the configuration loader: header layout, type codes,
// error codes and FSM states.
package nn_cfg_pkg;

   localparam int TYPE_MSB   = 31;
   localparam int TYPE_LSB   = 30;
   localparam int LAYER_MSB  = 29;
   localparam int LAYER_LSB  = 24;
   localparam int NEURON_MSB = 23;
   localparam int NEURON_LSB = 14;
   localparam int CNT_MSB    = 13;
   localparam int CNT_LSB    = 0;

   typedef enum logic [1:0] {
      TYPE_RSVD   = 2'b00,
      TYPE_WEIGHT = 2'b01,
      TYPE_BIAS   = 2'b10,
      TYPE_END    = 2'b11
   } cfg_type_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_ID    = 2'd1,
      ERR_COUNT = 2'd2,
      ERR_CSUM  = 2'd3
   } err_code_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WEIGHT,
      S_BIAS,
      S_SKIP,
      S_DONE
   } state_e;

endpackage

// File: rtl/nn_cfg_loader.sv
// Command-stream sequencer driving the shared weight/bias loading bus.
// Define NN_CFG_CHECKSUM_EN to verify a payload checksum carried in the end word.
module nn_cfg_loader
   import nn_cfg_pkg::*;
#(
   parameter int NUM_LAYERS  = 4,
   parameter int MAX_NEURONS = 32,
   parameter int MAX_WEIGHTS = 784
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cfg_data,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   output logic        weightValid,
   output logic        biasValid,
   output logic [31:0] weightValue,
   output logic [31:0] biasValue,
   output logic [31:0] config_layer_num,
   output logic [31:0] config_neuron_num,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   state_e    state, state_nx;
   logic [13:0] cnt, cnt_nx;
   err_code_e code_q, new_code;
   logic      set_err;
   logic      accept;

   cfg_type_e   hdr_type;
   logic [5:0]  hdr_layer;
   logic [9:0]  hdr_neuron;
   logic [13:0] hdr_cnt;
   logic        id_ok;

`ifdef NN_CFG_CHECKSUM_EN
   logic [31:0] sum;
`endif

   assign hdr_type   = cfg_type_e'(cfg_data[TYPE_MSB:TYPE_LSB]);
   assign hdr_layer  = cfg_data[LAYER_MSB:LAYER_LSB];
   assign hdr_neuron = cfg_data[NEURON_MSB:NEURON_LSB];
   assign hdr_cnt    = cfg_data[CNT_MSB:CNT_LSB];
   assign id_ok      = (32'(hdr_layer) < NUM_LAYERS) && (32'(hdr_neuron) < MAX_NEURONS);

   // Ready drops combinationally with rst so nothing is consumed in the reset cycle.
   assign cfg_ready = ~rst && (state != S_DONE);
   assign accept    = cfg_valid && cfg_ready;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);
   assign err_code  = code_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         err    <= 1'b0;
         code_q <= ERR_NONE;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         err   <= err | set_err;
         if (set_err && code_q == ERR_NONE) code_q <= new_code;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      set_err  = 1'b0;
      new_code = ERR_NONE;
      if (accept) begin
         case (state)
            S_IDLE: begin
               cnt_nx = hdr_cnt;
               case (hdr_type)
                  TYPE_WEIGHT: begin
                     if (hdr_cnt == '0 || 32'(hdr_cnt) > MAX_WEIGHTS) begin
                        set_err  = 1'b1;
                        new_code = ERR_COUNT;
                     end else if (!id_ok) begin
                        state_nx = S_SKIP;
                        set_err  = 1'b1;
                        new_code = ERR_ID;
                     end else begin
                        state_nx = S_WEIGHT;
                     end
                  end
                  TYPE_BIAS: begin
                     if (hdr_cnt != 14'd1) begin
                        set_err  = 1'b1;
                        new_code = ERR_COUNT;
                     end else if (!id_ok) begin
                        state_nx = S_SKIP;
                        set_err  = 1'b1;
                        new_code = ERR_ID;
                     end else begin
                        state_nx = S_BIAS;
                     end
                  end
                  TYPE_END: begin
                     state_nx = S_DONE;
`ifdef NN_CFG_CHECKSUM_EN
                     if (cfg_data[15:0] != sum[15:0]) begin
                        set_err  = 1'b1;
                        new_code = ERR_CSUM;
                     end
`endif
                  end
                  default: begin
                     set_err  = 1'b1;
                     new_code = ERR_COUNT;
                  end
               endcase
            end
            S_WEIGHT, S_BIAS, S_SKIP: begin
               cnt_nx = cnt - 14'd1;
               if (cnt == 14'd1) state_nx = S_IDLE;
            end
            default: ;
         endcase
      end
   end

   // Bus outputs are registered: a payload accepted at edge N shows up in cycle N+1.
   always_ff @(posedge clk) begin
      if (rst) begin
         weightValid       <= 1'b0;
         biasValid         <= 1'b0;
         weightValue       <= '0;
         biasValue         <= '0;
         config_layer_num  <= '0;
         config_neuron_num <= '0;
`ifdef NN_CFG_CHECKSUM_EN
         sum               <= '0;
`endif
      end else begin
         weightValid <= accept && (state == S_WEIGHT);
         biasValid   <= accept && (state == S_BIAS);
         if (accept && state == S_WEIGHT) weightValue <= cfg_data;
         if (accept && state == S_BIAS)   biasValue   <= cfg_data;
         if (accept && state == S_IDLE) begin
            config_layer_num  <= {26'd0, hdr_layer};
            config_neuron_num <= {22'd0, hdr_neuron};
         end
`ifdef NN_CFG_CHECKSUM_EN
         if (accept && (state == S_WEIGHT || state == S_BIAS)) sum <= sum + cfg_data;
`endif
      end
   end

endmodule

// File: tb/tb_nn_cfg_loader.sv
// Self-checking bench for nn_cfg_loader: directed scenarios plus random command
// streams compared against a command-level reference model.
module tb_nn_cfg_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cfg_data;
   logic        cfg_valid;
   logic        cfg_ready;
   logic        weightValid, biasValid;
   logic [31:0] weightValue, biasValue;
   logic [31:0] config_layer_num, config_neuron_num;
   logic        busy, done, err;
   logic [1:0]  err_code;

   int          n_vec = 0;
   int          n_bad = 0;
   int          exp_code = 0;
   logic [31:0] exp_sum = '0;

   nn_cfg_loader dut (
      .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready), .weightValid(weightValid), .biasValid(biasValid),
      .weightValue(weightValue), .biasValue(biasValue),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Idle gap cycles, then hold the word until accepted; returns #1 after the accepting edge.
   task automatic send_word(input logic [31:0] w, input int gaps);
      bit acc;
      int t;
      cfg_valid = 1'b0;
      for (int g = 0; g < gaps; g++) begin
         @(posedge clk); #1;
         chk("gap_strobe", 32'(weightValid | biasValid), 32'd0);
      end
      cfg_data  = w;
      cfg_valid = 1'b1;
      acc = 1'b0;
      t = 0;
      while (!acc && t < 20) begin
         acc = cfg_ready;
         @(posedge clk); #1;
         t++;
      end
      if (!acc) chk("accept_timeout", 32'd1, 32'd0);
      cfg_valid = 1'b0;
   endtask

   function automatic int pick_gap(input int g);
      return (g < 0) ? int'($urandom_range(2, 0)) : g;
   endfunction

   // Model: classify the whole command up front, then predict each payload's strobe.
   // kind 0 = rejected header, 1 = weight, 2 = bias, 3 = skipped.
   task automatic send_cmd(input logic [1:0] t, input int l, input int n, input int c,
                           input int base, input int hgap, input int pgap);
      int kind, code;
      logic [31:0] hdr, w;
      kind = 0;
      code = 0;
      if (t == 2'b00) code = 2;
      else if (t == 2'b01 && (c < 1 || c > 784)) code = 2;
      else if (t == 2'b10 && c != 1) code = 2;
      else if (l >= 4 || n >= 32) begin kind = 3; code = 1; end
      else kind = (t == 2'b01) ? 1 : 2;
      if (code != 0 && exp_code == 0) exp_code = code;

      hdr = {t, 6'(l), 10'(n), 14'(c)};
      send_word(hdr, pick_gap(hgap));
      chk("hdr_strobe", 32'(weightValid | biasValid), 32'd0);
      chk("hdr_busy", 32'(busy), 32'(kind != 0));
      if (kind != 0) begin
         for (int i = 0; i < c; i++) begin
            w = (base != 0) ? 32'(base + i) : $urandom;
            send_word(w, pick_gap(pgap));
            chk("w_strobe", 32'(weightValid), 32'(kind == 1));
            chk("b_strobe", 32'(biasValid), 32'(kind == 2));
            if (kind == 1) chk("w_value", weightValue, w);
            if (kind == 2) chk("b_value", biasValue, w);
            if (kind == 1 || kind == 2) begin
               chk("layer", config_layer_num, 32'(l));
               chk("neuron", config_neuron_num, 32'(n));
               exp_sum = exp_sum + w;
            end
            if (i == c - 1) chk("last_busy", 32'(busy), 32'd0);
         end
      end
      chk("err", 32'(err), 32'(exp_code != 0));
      chk("err_code", 32'(err_code), 32'(exp_code));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cfg_valid = 1'b0;
      cfg_data = '0;
      @(posedge clk); #1;
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0;
      exp_code = 0;
      exp_sum = '0;
      @(posedge clk); #1;
      chk("rst_ready_after", 32'(cfg_ready), 32'd1);
      chk("rst_strobes", 32'(weightValid | biasValid), 32'd0);
      chk("rst_wval", weightValue, 32'd0);
      chk("rst_bval", biasValue, 32'd0);
      chk("rst_layer", config_layer_num, 32'd0);
      chk("rst_neuron", config_neuron_num, 32'd0);
      chk("rst_flags", {28'd0, busy, done, err, 1'b0}, 32'd0);
      chk("rst_code", 32'(err_code), 32'd0);
   endtask

   task automatic send_end(input logic [31:0] w);
`ifdef NN_CFG_CHECKSUM_EN
      if (w[15:0] != exp_sum[15:0] && exp_code == 0) exp_code = 3;
`endif
      send_word(w, 0);
      chk("end_done", 32'(done), 32'd1);
      chk("end_ready", 32'(cfg_ready), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_err", 32'(err), 32'(exp_code != 0));
      chk("end_code", 32'(err_code), 32'(exp_code));
      cfg_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cfg_data = {2'b01, 6'd0, 10'd0, 14'd1};
         @(posedge clk); #1;
         chk("done_strobe", 32'(weightValid | biasValid), 32'd0);
         chk("done_hold", 32'(done), 32'd1);
      end
      cfg_valid = 1'b0;
   endtask

   initial begin
      logic [1:0] t;
      int r, c;
      logic [31:0] w;

      do_reset();

      // directed scenarios
      send_cmd(2'b01, 1, 3, 4, 32'h11, 0, 0);
      send_cmd(2'b10, 0, 7, 1, 32'hFFF0, 0, 3);
      send_cmd(2'b01, 9, 0, 2, 0, 0, 0);
      send_cmd(2'b01, 2, 31, 3, 0, 0, 0);
      send_cmd(2'b01, 0, 0, 0, 0, 0, 0);
      send_cmd(2'b10, 0, 0, 2, 0, 0, 0);
      send_cmd(2'b01, 3, 0, 784, 0, 0, 0);

      // randomized command stream
      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(9, 0));
         if (r == 0) begin t = 2'b00; c = int'($urandom_range(3, 0)); end
         else if (r <= 5) begin t = 2'b01; c = int'($urandom_range(6, 1)); end
         else if (r <= 8) begin t = 2'b10; c = ($urandom_range(4, 0) == 0) ? 2 : 1; end
         else begin t = 2'b01; c = ($urandom_range(1, 0) == 0) ? 0 : 785; end
         send_cmd(t, int'($urandom_range(4, 0)), int'($urandom_range(34, 0)), c, 0, -1, -1);
      end

      w = {2'b11, 14'($urandom), exp_sum[15:0]};
      send_end(w);

      // reset in the middle of a burst
      do_reset();
      send_word({2'b01, 6'd2, 10'd5, 14'd5}, 0);
      send_word(32'hA1, 0);
      chk("mid_w1", weightValue, 32'hA1);
      send_word(32'hA2, 0);
      chk("mid_w2", weightValue, 32'hA2);
      rst = 1'b1;
      cfg_valid = 1'b1;
      cfg_data = 32'hA3;
      @(posedge clk); #1;
      chk("mid_strobe", 32'(weightValid | biasValid), 32'd0);
      chk("mid_wval", weightValue, 32'd0);
      chk("mid_layer", config_layer_num, 32'd0);
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_ready", 32'(cfg_ready), 32'd0);
      rst = 1'b0;
      cfg_valid = 1'b0;
      exp_code = 0;
      exp_sum = '0;
      @(posedge clk); #1;
      chk("mid_strobe2", 32'(weightValid | biasValid), 32'd0);
      chk("mid_ready2", 32'(cfg_ready), 32'd1);

      // checksum-bearing end after weights 1,2,3
      send_cmd(2'b01, 0, 0, 3, 1, 0, 0);
      send_end({2'b11, 14'd0, 16'd5});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   always @(negedge clk) begin
      if (weightValid && biasValid) begin
         n_vec++;
         n_bad++;
         $display("FAIL both_strobes got=1 exp=0");
      end
   end

endmodule
